// File: rtl/mxint8_block_quantizer_pkg.sv
// mxint8_block_quantizer_pkg
// Shared widths, constants and FSM state type for the float32 -> MXINT8 block quantizer.
// The width macros may be overridden on the command line; defaults apply otherwise.
// Optional feature macro used by the top: MXINT8_QUANT_SAT_CNT_EN.

`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

package mxint8_block_quantizer_pkg;

    localparam int unsigned BlockSize    = `BLOCK_SIZE;
    localparam int unsigned ScaleWidth   = `SCALE_WIDTH;
    localparam int unsigned ElemWidth    = `MXINT8_ELEMENT_WIDTH;
    localparam int unsigned Float32Width = `FLOAT32_WIDTH;

    // E8M0 encoding reserved for NaN.
    localparam logic [7:0] E8m0Nan = 8'hFF;

    // Largest INT8 magnitude produced; -128 is never emitted.
    localparam int unsigned Int8Max = 127;

    typedef enum logic [1:0] {
        COLLECT,
        QUANT,
        OUT
    } state_e;

endpackage

// File: rtl/mxint8_elem_quant.sv
// mxint8_elem_quant
// Combinational quantizer for one element: aligns a float32 to the shared exponent,
// rounds to nearest (ties away from zero), clamps to +/-127 and applies the sign.
// Ports:
//   i_float32    - IEEE-754 single input (zero/denormal treated as zero)
//   i_shared_exp - shared biased exponent of the block (>= element exponent)
//   o_elem       - two's-complement INT8 element with implicit 2^-6 scaling
//   o_sat        - magnitude was clamped to 127

module mxint8_elem_quant
    import mxint8_block_quantizer_pkg::*;
(
    input  logic [31:0] i_float32,
    input  logic [7:0]  i_shared_exp,
    output logic [7:0]  o_elem,
    output logic        o_sat
);

    logic [7:0]  exp_in;
    logic [23:0] mant;
    logic [8:0]  shift;
    logic [7:0]  tail;
    logic [7:0]  mag;
    logic [6:0]  clamped;

    always_comb begin
        exp_in = i_float32[30:23];
        mant   = {1'b1, i_float32[22:0]};
        shift  = 9'd17 + {1'b0, 8'(i_shared_exp - exp_in)};
        tail   = '0;
        mag    = '0;
        if ((exp_in != 8'd0) && (shift <= 9'd24)) begin
            // Keep one extra bit below the LSB; it is the rounding bit.
            tail = 8'(mant >> (shift - 9'd1));
            mag  = {1'b0, tail[7:1]} + {7'd0, tail[0]};
        end
        o_sat   = (mag > 8'(Int8Max));
        clamped = o_sat ? 7'(Int8Max) : mag[6:0];
        o_elem  = i_float32[31] ? (8'd0 - {1'b0, clamped}) : {1'b0, clamped};
    end

endmodule

// File: rtl/mxint8_block_quantizer.sv
// mxint8_block_quantizer
// Streaming float32 -> MXINT8 encoder. Collects BLOCK_SIZE scalars, derives the shared
// E8M0 scale from the largest exponent, quantizes one element per cycle and presents
// the finished block on a valid/ready output.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   i_valid / o_in_ready   - input element handshake, i_float32 data
//   o_valid / i_out_ready  - output block handshake
//   o_scale                - shared E8M0 scale (0xFF on NaN/Inf)
//   o_mxint8_elements      - quantized INT8 elements
//   o_nan                  - block contained NaN/Inf
//   o_sat_count            - clamped-element count (only with MXINT8_QUANT_SAT_CNT_EN)

module mxint8_block_quantizer
    import mxint8_block_quantizer_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE  = BlockSize,
    parameter int unsigned SCALE_WIDTH = ScaleWidth,
    parameter int unsigned ELEM_WIDTH  = ElemWidth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    o_in_ready,
    input  logic [Float32Width-1:0] i_float32,
    output logic                    o_valid,
    input  logic                    i_out_ready,
    output logic [SCALE_WIDTH-1:0]  o_scale,
    output logic [ELEM_WIDTH-1:0]   o_mxint8_elements [BLOCK_SIZE-1:0],
`ifdef MXINT8_QUANT_SAT_CNT_EN
    output logic [$clog2(BLOCK_SIZE+1)-1:0] o_sat_count,
`endif
    output logic                    o_nan
);

    localparam int unsigned IdxW = $clog2(BLOCK_SIZE);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BLOCK_SIZE - 1);

    state_e                  state_q;
    logic [IdxW-1:0]         idx_q;
    logic [IdxW-1:0]         qidx_q;
    logic [7:0]              max_exp_q;
    logic                    nan_q;
    logic                    nan_out_q;
    logic [SCALE_WIDTH-1:0]  scale_q;
    logic [ELEM_WIDTH-1:0]   elems_q [BLOCK_SIZE-1:0];
    logic [31:0]             buf_q [BLOCK_SIZE-1:0];
    logic [7:0]              in_exp;
    logic [7:0]              q_elem;
    logic                    q_sat;

    assign in_exp = i_float32[30:23];

    mxint8_elem_quant u_elem_quant (
        .i_float32    (buf_q[qidx_q]),
        .i_shared_exp (max_exp_q),
        .o_elem       (q_elem),
        .o_sat        (q_sat)
    );

    // Element storage needs no reset: every slot is rewritten before it is quantized.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == COLLECT) && i_valid) begin
            buf_q[idx_q] <= i_float32;
        end
    end

`ifdef MXINT8_QUANT_SAT_CNT_EN
    logic [$clog2(BLOCK_SIZE+1)-1:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (state_q == QUANT) begin
            sat_cnt_q <= ((qidx_q == '0) ? '0 : sat_cnt_q)
                         + ($clog2(BLOCK_SIZE+1))'(q_sat && !nan_q);
        end else if ((state_q == OUT) && i_out_ready) begin
            sat_cnt_q <= '0;
        end
    end

    assign o_sat_count = sat_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            qidx_q    <= '0;
            max_exp_q <= '0;
            nan_q     <= 1'b0;
            nan_out_q <= 1'b0;
            scale_q   <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                elems_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (i_valid) begin
                        // Zero/denormal inputs have exponent 0 and never raise the max.
                        if (in_exp == E8m0Nan) begin
                            nan_q <= 1'b1;
                        end else if (in_exp > max_exp_q) begin
                            max_exp_q <= in_exp;
                        end
                        if (idx_q == IdxLast) begin
                            state_q <= QUANT;
                            idx_q   <= '0;
                            qidx_q  <= '0;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end
                end
                QUANT: begin
                    elems_q[qidx_q] <= nan_q ? '0 : ELEM_WIDTH'(q_elem);
                    if (qidx_q == '0) begin
                        scale_q   <= nan_q ? SCALE_WIDTH'(E8m0Nan) : SCALE_WIDTH'(max_exp_q);
                        nan_out_q <= nan_q;
                    end
                    if (qidx_q == IdxLast) begin
                        state_q <= OUT;
                    end else begin
                        qidx_q <= qidx_q + IdxW'(1);
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        state_q   <= COLLECT;
                        idx_q     <= '0;
                        max_exp_q <= '0;
                        nan_q     <= 1'b0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign o_in_ready        = (state_q == COLLECT);
    assign o_valid           = (state_q == OUT);
    assign o_scale           = scale_q;
    assign o_nan             = nan_out_q;
    assign o_mxint8_elements = elems_q;

endmodule
